// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one byte-wide UART
//            transmitter among N_REQ requesters. One byte is granted per
//            START; a requester may keep the transmitter for up to MAX_BURST
//            back-to-back bytes. A transmitter that never raises tx_busy
//            after a start sets the sticky err flag.
// Ports    : clk, rst       - clock, asynchronous active-high reset
//            req, req_data  - per-requester byte pending / flattened bytes
//            ack            - one-cycle "byte latched" pulse, one-hot
//            tx_data, tx_start, tx_busy - transmitter byte handshake
//            grant_id       - current/last granted requester
//            active         - high whenever the sequencer is not idle
//            err            - sticky transmitter busy timeout
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int BUSY_TO   = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [N_REQ-1:0]           ack,
    output logic [DATA_W-1:0]          tx_data,
    output logic                       tx_start,
    input  logic                       tx_busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       active,
    output logic                       err
);

    localparam int c_IDX_W   = $clog2(N_REQ);
    localparam int c_BURST_W = $clog2(MAX_BURST + 1);
    localparam int c_TO_W    = $clog2(BUSY_TO + 1);
    // The START cycle counts as the first timeout cycle and the counter is
    // cleared there, so WAIT_BUSY gives up when it holds BUSY_TO-2: err is
    // then visible exactly BUSY_TO cycles after the tx_start cycle.
    localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(BUSY_TO - 2);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [c_IDX_W-1:0]     r_ptr;
    logic [c_IDX_W-1:0]     r_grant;
    logic [c_BURST_W-1:0]   r_burst_cnt;
    logic [c_TO_W-1:0]      r_to_cnt;
    logic [DATA_W-1:0]      r_tx_data;
    logic                   r_err;

    logic [c_IDX_W-1:0]     w_cand;
    logic [c_IDX_W-1:0]     w_winner;
    logic [c_IDX_W-1:0]     w_grant_inc;
    logic [c_IDX_W-1:0]     w_sel_id;
    logic [DATA_W-1:0]      w_sel_data;
    logic                   w_any_req;
    logic                   w_burst_more;
    logic                   w_load_new;
    logic                   w_load_burst;
    logic                   w_rotate;
    logic                   w_timeout;

    // ------------------------------------------------------------------
    // Round-robin search: walk offsets from the highest down so the last
    // hit (smallest offset from r_ptr) wins.
    // ------------------------------------------------------------------
    always_comb begin
        w_winner = r_ptr;
        w_cand   = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_cand = c_IDX_W'((int'(r_ptr) + i) % N_REQ);
            if (req[w_cand]) begin
                w_winner = w_cand;
            end
        end
    end

    assign w_any_req    = |req;
    assign w_grant_inc  = (r_grant == c_IDX_LAST) ? '0 : r_grant + 1'b1;
    assign w_burst_more = (int'(r_burst_cnt) + 1) < MAX_BURST;

    // Byte source: the new winner when leaving IDLE, else the burst owner.
    assign w_sel_id = (r_state == S_IDLE) ? w_winner : r_grant;

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (c_IDX_W'(i) == w_sel_id) begin
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_load_new   = 1'b0;
        w_load_burst = 1'b0;
        w_rotate     = 1'b0;
        w_timeout    = 1'b0;
        tx_start     = 1'b0;
        ack          = '0;
        active       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_load_new   = 1'b1;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                // Transfer was committed on entry; ack regardless of req.
                tx_start       = 1'b1;
                ack[r_grant]   = 1'b1;
                w_state_next   = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_next = S_WAIT_DONE;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (req[r_grant] && w_burst_more) begin
                        w_load_burst = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_rotate     = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: grant, byte, pointer, counters, sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_grant     <= '0;
            r_burst_cnt <= '0;
            r_to_cnt    <= '0;
            r_tx_data   <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_load_new) begin
                r_grant     <= w_winner;
                r_burst_cnt <= '0;
            end
            if (w_load_new || w_load_burst) begin
                r_tx_data <= w_sel_data;
            end
            if ((r_state == S_WAIT_DONE) && !tx_busy) begin
                r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            if (r_state == S_START) begin
                r_to_cnt <= '0;
            end else if ((r_state == S_WAIT_BUSY) && !tx_busy) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
            if (w_timeout || w_rotate) begin
                r_ptr <= w_grant_inc;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign grant_id = r_grant;
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Self-checking bench for uart_tx_arbiter. Two instances run side
//            by side: one with default parameters, one with MAX_BURST=1 and
//            a short BUSY_TO. Each requester is a byte queue; the bench also
//            plays the transmitter. A transaction-level reference predicts
//            every start, the granted requester and its byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int MB0 = 16;
    localparam int TO0 = 15;
    localparam int MB1 = 1;
    localparam int TO1 = 6;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req      [2];
    logic [N*W-1:0]   req_data [2];
    logic [N-1:0]     ack      [2];
    logic [W-1:0]     txd      [2];
    logic             txs      [2];
    logic             busy     [2];
    logic [1:0]       gid      [2];
    logic             act      [2];
    logic             errv     [2];

    uart_tx_arbiter u_dut0 (
        .clk(clk), .rst(rst), .req(req[0]), .req_data(req_data[0]),
        .ack(ack[0]), .tx_data(txd[0]), .tx_start(txs[0]), .tx_busy(busy[0]),
        .grant_id(gid[0]), .active(act[0]), .err(errv[0])
    );

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB1), .BUSY_TO(TO1)) u_dut1 (
        .clk(clk), .rst(rst), .req(req[1]), .req_data(req_data[1]),
        .ack(ack[1]), .tx_data(txd[1]), .tx_start(txs[1]), .tx_busy(busy[1]),
        .grant_id(gid[1]), .active(act[1]), .err(errv[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester byte queues, one per dut and requester
    logic [W-1:0] q [2][N][$];

    // Reference state: per dut, what the arbiter is doing at transfer level
    int          n;           // posedge count
    int          m_busy_xfer[2];
    int          m_ptr[2];
    int          m_g[2];
    int          m_nbytes[2];
    int          m_s[2];
    int          m_end[2];
    int          pd[2];
    bit          m_dead[2];
    bit          dead[2];
    bit          m_err[2];
    logic [W-1:0] m_data[2];

    int n_cmp;
    int n_fail;

    function automatic int mb(input int k);
        return (k == 0) ? MB0 : MB1;
    endfunction

    function automatic int bto(input int k);
        return (k == 0) ? TO0 : TO1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_busy_xfer[k] = 0; m_ptr[k] = 0; m_g[k] = 0; m_nbytes[k] = 0;
            m_s[k] = 0; m_end[k] = 0; pd[k] = 1; m_dead[k] = 0;
            m_err[k] = 0; m_data[k] = '0;
            for (int i = 0; i < N; i++) q[k][i].delete();
        end
    endtask

    // Drive requester and transmitter inputs for the next rising edge.
    task automatic drive();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                req[k][i] = (q[k][i].size() > 0);
                req_data[k][i*W +: W] = (q[k][i].size() > 0) ? q[k][i][0] : '0;
            end
            busy[k] = (m_busy_xfer[k] == 1) && !m_dead[k] &&
                      (n + 1 >= m_s[k] + 1 + pd[k]) && (n + 1 < m_end[k]);
        end
    endtask

    // Predict and check one cycle of dut k (called just after edge n).
    task automatic evaluate(input int k);
        bit           exp_start;
        bit           found;
        int           eid;
        logic [N-1:0] exp_ack;
        exp_start = 0;
        found     = 0;
        eid       = m_g[k];
        if (m_busy_xfer[k] == 1) begin
            if (!m_dead[k] && n == m_end[k]) begin
                // Frame finished: owner keeps the line if still asking and under the cap
                if (req[k][m_g[k]] && m_nbytes[k] < mb(k)) begin
                    exp_start = 1;
                    m_nbytes[k]++;
                end else begin
                    m_ptr[k] = (m_g[k] + 1) % N;
                    m_busy_xfer[k] = 0;
                end
            end else if (m_dead[k] && n == m_s[k] + bto(k)) begin
                m_err[k] = 1;
                m_ptr[k] = (m_g[k] + 1) % N;
                m_busy_xfer[k] = 0;
            end
        end else if (req[k] != '0) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[k][(m_ptr[k] + j) % N]) begin
                    eid   = (m_ptr[k] + j) % N;
                    found = 1;
                end
            end
            exp_start   = 1;
            m_nbytes[k] = 1;
        end
        exp_ack = '0;
        if (exp_start) begin
            exp_ack[eid]   = 1'b1;
            m_data[k]      = (q[k][eid].size() > 0) ? q[k][eid][0] : 'x;
            if (q[k][eid].size() > 0) void'(q[k][eid].pop_front());
            m_g[k]         = eid;
            m_busy_xfer[k] = 1;
            m_s[k]         = n;
            m_dead[k]      = dead[k];
            pd[k]          = int'($urandom_range(1, 3));
            m_end[k]       = n + 1 + pd[k] + int'($urandom_range(1, 5));
        end
        chk($sformatf("d%0d_tx_start", k), 32'(txs[k]), 32'(exp_start));
        chk($sformatf("d%0d_ack", k), 32'(ack[k]), 32'(exp_ack));
        chk($sformatf("d%0d_grant_id", k), 32'(gid[k]), 32'(m_g[k]));
        chk($sformatf("d%0d_tx_data", k), 32'(txd[k]), 32'(m_data[k]));
        chk($sformatf("d%0d_active", k), 32'(act[k]), 32'(m_busy_xfer[k]));
        chk($sformatf("d%0d_err", k), 32'(errv[k]), 32'(m_err[k]));
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        n++;
        @(negedge clk);
        evaluate(0);
        evaluate(1);
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_d%0d_tx_start", tag, k), 32'(txs[k]), 32'(0));
            chk($sformatf("%s_d%0d_ack", tag, k), 32'(ack[k]), 32'(0));
            chk($sformatf("%s_d%0d_tx_data", tag, k), 32'(txd[k]), 32'(0));
            chk($sformatf("%s_d%0d_grant_id", tag, k), 32'(gid[k]), 32'(0));
            chk($sformatf("%s_d%0d_active", tag, k), 32'(act[k]), 32'(0));
            chk($sformatf("%s_d%0d_err", tag, k), 32'(errv[k]), 32'(0));
        end
    endtask

    function automatic bit all_idle();
        bit r;
        r = (m_busy_xfer[0] == 0) && (m_busy_xfer[1] == 0);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                if (q[k][i].size() > 0) r = 0;
        return r;
    endfunction

    task automatic drain(input string tag);
        bit done;
        done = 0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (all_idle()) done = 1;
            else step();
        end
        chk({tag, "_drain_done"}, 32'(done), 32'(1));
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        n      = 0;
        dead[0] = 0;
        dead[1] = 0;
        rst = 1'b1;
        model_reset();
        drive();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b0;

        // Single requester 2, byte 0x5A
        q[0][2].push_back(8'h5A);
        q[1][2].push_back(8'h5A);
        drain("single");

        // All four requesting: dut1 (MAX_BURST=1) must rotate 0,1,2,3,0,...
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < N; i++)
                for (int b = 0; b < 3; b++)
                    q[k][i].push_back(8'((i << 4) | b));
        drain("rr");

        // Burst on requester 1 (0x01..0x20), requester 0 joins after first grant
        for (int b = 1; b <= 32; b++) q[0][1].push_back(8'(b));
        step();
        q[0][0].push_back(8'hA0);
        drain("burst");

        // One-cycle request pulse on requester 3
        q[0][3].push_back(8'h3C);
        q[1][3].push_back(8'hC3);
        drain("pulse");

        // Dead transmitter: each start times out, err sticks
        dead[0] = 1;
        dead[1] = 1;
        q[0][0].push_back(8'h11);
        q[0][0].push_back(8'h12);
        q[1][0].push_back(8'h21);
        q[1][1].push_back(8'h22);
        drain("timeout");
        dead[0] = 0;
        dead[1] = 0;

        // Randomised traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                int k;
                int i;
                k = int'($urandom_range(0, 1));
                i = int'($urandom_range(0, N - 1));
                if (q[k][i].size() < 6) q[k][i].push_back(8'($urandom));
            end
            step();
        end
        drain("random");

        // Asynchronous reset while dut0 waits for the frame to finish
        begin
            bit hit;
            hit = 0;
            q[0][1].push_back(8'h71);
            q[0][1].push_back(8'h72);
            for (int c = 0; c < 200 && !hit; c++) begin
                step();
                if (m_busy_xfer[0] == 1 && !m_dead[0] &&
                    n >= m_s[0] + 1 + pd[0] && n < m_end[0]) hit = 1;
            end
            chk("reach_wait_done", 32'(hit), 32'(1));
        end
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        drive();
        @(posedge clk);
        n++;
        @(negedge clk);
        q[0][2].push_back(8'hE2);
        q[1][2].push_back(8'hE3);
        rst = 1'b0;
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
